wb_mem_responder: RTL and testbench

WB_MEM_RESPONDER -- requirements
Module: wb_mem_responder

---
 rtl/wb_mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_wb_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wb_mem_responder
// Brief    : Dual-port (instruction + data) Wishbone memory with wait states.
// Revision : 1.0 - initial release
// ============================================================================
module wb_mem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iaddr_i,
    input  logic        icyc_i,
    input  logic        istb_i,
    output logic [31:0] idat_o,
    output logic        iack_o,
    output logic        ierr_o,
    input  logic [31:0] daddr_i,
    input  logic [31:0] ddat_i,
    input  logic [3:0]  dsel_i,
    input  logic        dcyc_i,
    input  logic        dstb_i,
    input  logic        dwe_i,
    output logic [31:0] ddat_o,
    output logic        dack_o,
    output logic        derr_o
);

    localparam int         c_depth = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_wait  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    logic [31:0] r_mem [0:c_depth-1];

    state_t                r_i_state, r_d_state;
    logic [3:0]            r_i_cnt, r_d_cnt;
    logic [ADDR_WIDTH-1:0] r_i_idx, r_d_idx;
    logic [31:0]           r_i_rdata, r_d_rdata, r_d_wdat;
    logic [3:0]            r_d_sel;
    logic                  r_d_we;

    // A borrow out of the subtraction lands in bit 32, so one shift test covers both bounds
    logic [32:0] w_i_off, w_d_off;
    logic        w_i_valid, w_d_valid, w_i_start, w_d_start;
    logic        w_i_enter_ack, w_d_enter_ack, w_d_commit;
    logic [ADDR_WIDTH-1:0] w_i_idx, w_d_idx;
    logic [31:0] w_d_wdat;
    logic [3:0]  w_d_sel;
    logic        w_d_we;

    assign w_i_off   = {1'b0, iaddr_i} - {1'b0, BASE_ADDR};
    assign w_d_off   = {1'b0, daddr_i} - {1'b0, BASE_ADDR};
    assign w_i_valid = (iaddr_i[1:0] == 2'b00) && ((w_i_off >> (ADDR_WIDTH + 2)) == 33'd0);
    assign w_d_valid = (daddr_i[1:0] == 2'b00) && ((w_d_off >> (ADDR_WIDTH + 2)) == 33'd0);
    assign w_i_start = (r_i_state == S_IDLE) && icyc_i && istb_i;
    assign w_d_start = (r_d_state == S_IDLE) && dcyc_i && dstb_i;

    // With zero wait states the access happens on the request edge itself, using live inputs
    assign w_i_enter_ack = (w_i_start && w_i_valid && (c_wait == 4'd0)) ||
                           ((r_i_state == S_WAIT) && icyc_i && (r_i_cnt == 4'd1));
    assign w_d_enter_ack = (w_d_start && w_d_valid && (c_wait == 4'd0)) ||
                           ((r_d_state == S_WAIT) && dcyc_i && (r_d_cnt == 4'd1));

    assign w_i_idx  = (r_i_state == S_IDLE) ? iaddr_i[ADDR_WIDTH+1:2] : r_i_idx;
    assign w_d_idx  = (r_d_state == S_IDLE) ? daddr_i[ADDR_WIDTH+1:2] : r_d_idx;
    assign w_d_wdat = (r_d_state == S_IDLE) ? ddat_i : r_d_wdat;
    assign w_d_sel  = (r_d_state == S_IDLE) ? dsel_i : r_d_sel;
    assign w_d_we   = (r_d_state == S_IDLE) ? dwe_i  : r_d_we;
    assign w_d_commit = !rst && w_d_enter_ack && w_d_we;

    // Storage has no reset; reads elsewhere see the pre-write word on a collision
    always_ff @(posedge clk) begin
        if (w_d_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_d_sel[b]) r_mem[w_d_idx][8*b +: 8] <= w_d_wdat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_state <= S_IDLE;
            r_i_cnt   <= 4'd0;
            r_i_idx   <= '0;
            r_i_rdata <= 32'h0;
            iack_o    <= 1'b0;
            ierr_o    <= 1'b0;
            idat_o    <= 32'h0;
        end else begin
            iack_o <= 1'b0;
            ierr_o <= 1'b0;
            idat_o <= 32'h0;
            if (w_i_enter_ack) r_i_rdata <= r_mem[w_i_idx];
            case (r_i_state)
                S_IDLE: begin
                    if (w_i_start) begin
                        if (!w_i_valid) begin
                            r_i_state <= S_ERR;
                        end else begin
                            r_i_idx   <= iaddr_i[ADDR_WIDTH+1:2];
                            r_i_cnt   <= c_wait;
                            r_i_state <= (c_wait == 4'd0) ? S_ACK : S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!icyc_i) begin
                        r_i_cnt   <= 4'd0;
                        r_i_state <= S_IDLE;
                    end else begin
                        r_i_cnt <= r_i_cnt - 4'd1;
                        if (r_i_cnt == 4'd1) r_i_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    iack_o    <= 1'b1;
                    idat_o    <= r_i_rdata;
                    r_i_state <= S_IDLE;
                end
                default: begin
                    ierr_o    <= 1'b1;
                    r_i_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_state <= S_IDLE;
            r_d_cnt   <= 4'd0;
            r_d_idx   <= '0;
            r_d_rdata <= 32'h0;
            r_d_wdat  <= 32'h0;
            r_d_sel   <= 4'h0;
            r_d_we    <= 1'b0;
            dack_o    <= 1'b0;
            derr_o    <= 1'b0;
            ddat_o    <= 32'h0;
        end else begin
            dack_o <= 1'b0;
            derr_o <= 1'b0;
            ddat_o <= 32'h0;
            if (w_d_enter_ack) r_d_rdata <= r_mem[w_d_idx];
            case (r_d_state)
                S_IDLE: begin
                    if (w_d_start) begin
                        if (!w_d_valid) begin
                            r_d_state <= S_ERR;
                        end else begin
                            r_d_idx   <= daddr_i[ADDR_WIDTH+1:2];
                            r_d_wdat  <= ddat_i;
                            r_d_sel   <= dsel_i;
                            r_d_we    <= dwe_i;
                            r_d_cnt   <= c_wait;
                            r_d_state <= (c_wait == 4'd0) ? S_ACK : S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!dcyc_i) begin
                        r_d_cnt   <= 4'd0;
                        r_d_state <= S_IDLE;
                    end else begin
                        r_d_cnt <= r_d_cnt - 4'd1;
                        if (r_d_cnt == 4'd1) r_d_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    dack_o    <= 1'b1;
                    ddat_o    <= r_d_rdata;
                    r_d_state <= S_IDLE;
                end
                default: begin
                    derr_o    <= 1'b1;
                    r_d_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_wb_mem_responder
// Brief    : Randomized scoreboard bench for wb_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_mem_responder;

    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          W    = 3;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] iaddr, idat, daddr, ddat_w, ddat_r;
    logic        icyc, istb, iack, ierr;
    logic [3:0]  dsel;
    logic        dcyc, dstb, dwe, dack, derr;

    wb_mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .iaddr_i(iaddr), .icyc_i(icyc), .istb_i(istb),
        .idat_o(idat), .iack_o(iack), .ierr_o(ierr),
        .daddr_i(daddr), .ddat_i(ddat_w), .dsel_i(dsel),
        .dcyc_i(dcyc), .dstb_i(dstb), .dwe_i(dwe),
        .ddat_o(ddat_r), .dack_o(dack), .derr_o(derr)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        iq[$];
    exp_t        dq[$];
    logic [31:0] mdl [0:(1<<AW)-1];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic bit addr_valid(input logic [31:0] a);
        longint off;
        off = longint'({32'b0, a}) - longint'({32'b0, BASE});
        return (a % 4 == 0) && (off >= 0) && (off < 4 * (longint'(1) << AW));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] pick_addr();
        int r;
        r = int'($urandom % 10);
        if (r < 7)  return BASE + 4 * (($urandom % 2) ? ($urandom % 16) : (1020 + $urandom % 4));
        if (r == 7) return BASE + 4 * ($urandom % 16) + 1 + ($urandom % 3);
        if (r == 8) return BASE + 32'h1000 + 4 * ($urandom % 256);
        return 32'hFFFF_0000 | ($urandom & 32'hFFFC);
    endfunction

    // Scoreboard monitor: pops an expectation whenever a port responds
    always @(negedge clk) begin
        exp_t e;
        if (!iack) check("i_dat_idle", idat, 32'h0);
        if (iack || ierr) begin
            check("i_ack_err_excl", {31'b0, iack & ierr}, 32'h0);
            if (iq.size() == 0) check("i_unexpected", {30'b0, ierr, iack}, 32'h0);
            else begin
                e = iq.pop_front();
                check("i_kind", {30'b0, ierr, iack}, e.is_err ? 32'h2 : 32'h1);
                check("i_time", 32'(cycle), 32'(e.due));
                if (e.chk_data && iack) check("i_data", idat, e.data);
            end
        end else if (iq.size() > 0 && iq[0].due <= cycle) begin
            check("i_missing", 32'h0, 32'h1);
            void'(iq.pop_front());
        end

        if (!dack) check("d_dat_idle", ddat_r, 32'h0);
        if (dack || derr) begin
            check("d_ack_err_excl", {31'b0, dack & derr}, 32'h0);
            if (dq.size() == 0) check("d_unexpected", {30'b0, derr, dack}, 32'h0);
            else begin
                e = dq.pop_front();
                check("d_kind", {30'b0, derr, dack}, e.is_err ? 32'h2 : 32'h1);
                check("d_time", 32'(cycle), 32'(e.due));
                if (e.chk_data && dack) check("d_data", ddat_r, e.data);
            end
        end else if (dq.size() > 0 && dq[0].due <= cycle) begin
            check("d_missing", 32'h0, 32'h1);
            void'(dq.pop_front());
        end
    end

    // Called at a negedge; the request edge is the following posedge
    task automatic i_txn(input logic [31:0] a);
        bit   v, done;
        int   n;
        exp_t e;
        v = addr_valid(a);
        n = cycle + 1;
        done = 0;
        iaddr = a; icyc = 1'b1; istb = 1'b1;
        if (!v) begin
            e = '{is_err: 1'b1, chk_data: 1'b0, data: 32'h0, due: n + 1};
            iq.push_back(e);
        end else if (W == 0) begin
            e = '{is_err: 1'b0, chk_data: 1'b1, data: mdl[widx(a)], due: n + W + 1};
            iq.push_back(e);
        end
        for (int k = 0; k < W + 8 && !done; k++) begin
            @(negedge clk);
            if (iack || ierr) done = 1;
            else begin
                // Snapshot just before the read edge: earlier writes visible, same-edge write not
                if (v && W > 0 && cycle == n + W - 1) begin
                    e = '{is_err: 1'b0, chk_data: 1'b1, data: mdl[widx(a)], due: n + W + 1};
                    iq.push_back(e);
                end
                iaddr = $urandom;
                istb  = 1'($urandom % 2);
            end
        end
        if (!done) check("i_timeout", 32'h0, 32'h1);
        icyc = 1'b0; istb = 1'b0;
    endtask

    task automatic d_txn(input logic [31:0] a, input logic we, input logic [3:0] sel,
                         input logic [31:0] wd, input int abort_req);
        bit   v, done;
        int   n, abort_at;
        exp_t e;
        v = addr_valid(a);
        abort_at = v ? abort_req : 0;
        n = cycle + 1;
        done = 0;
        daddr = a; ddat_w = wd; dsel = sel; dwe = we; dcyc = 1'b1; dstb = 1'b1;
        if (!v) begin
            e = '{is_err: 1'b1, chk_data: 1'b0, data: 32'h0, due: n + 1};
            dq.push_back(e);
        end else if (abort_at == 0) begin
            if (we) begin
                e = '{is_err: 1'b0, chk_data: 1'b0, data: 32'h0, due: n + W + 1};
                dq.push_back(e);
            end else if (W == 0) begin
                e = '{is_err: 1'b0, chk_data: 1'b1, data: mdl[widx(a)], due: n + W + 1};
                dq.push_back(e);
            end
        end
        for (int k = 0; k < W + 8 && !done; k++) begin
            @(posedge clk);
            #1;
            if (v && we && abort_at == 0 && cycle == n + W) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) mdl[widx(a)][8*b +: 8] = wd[8*b +: 8];
            end
            @(negedge clk);
            if (dack || derr) done = 1;
            else if (abort_at > 0 && cycle == n + abort_at - 1) begin
                dcyc = 1'b0; dstb = 1'b0;
                @(negedge clk);
                done = 1;
            end else begin
                if (v && !we && abort_at == 0 && W > 0 && cycle == n + W - 1) begin
                    e = '{is_err: 1'b0, chk_data: 1'b1, data: mdl[widx(a)], due: n + W + 1};
                    dq.push_back(e);
                end
                daddr  = $urandom;
                ddat_w = $urandom;
                dsel   = 4'($urandom);
                dwe    = 1'($urandom % 2);
                dstb   = 1'($urandom % 2);
            end
        end
        if (!done) check("d_timeout", 32'h0, 32'h1);
        dcyc = 1'b0; dstb = 1'b0; dwe = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        iaddr = 32'h0; icyc = 1'b0; istb = 1'b0;
        daddr = 32'h0; ddat_w = 32'h0; dsel = 4'h0; dcyc = 1'b0; dstb = 1'b0; dwe = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_iack", {31'b0, iack}, 32'h0);
        check("rst_ierr", {31'b0, ierr}, 32'h0);
        check("rst_idat", idat, 32'h0);
        check("rst_dack", {31'b0, dack}, 32'h0);
        check("rst_derr", {31'b0, derr}, 32'h0);
        check("rst_ddat", ddat_r, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) d_txn(BASE + 4 * i, 1'b1, 4'hF, $urandom, 0);
        for (int i = 1020; i < 1024; i++) d_txn(BASE + 4 * i, 1'b1, 4'hF, $urandom, 0);

        // Full write/read, then a single-lane update
        d_txn(BASE + 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 0);
        d_txn(BASE + 32'h10, 1'b0, 4'h0, 32'h0, 0);
        d_txn(BASE + 32'h10, 1'b1, 4'b0001, 32'h000000AA, 0);
        d_txn(BASE + 32'h10, 1'b0, 4'h3, 32'h0, 0);

        fork
            i_txn(BASE + 32'h2);
            d_txn(BASE + 32'h1000, 1'b0, 4'hF, 32'h0, 0);
        join

        d_txn(BASE + 32'h18, 1'b1, 4'hF, 32'hCAFEF00D, 2);
        repeat (W + 2) @(negedge clk);
        d_txn(BASE + 32'h18, 1'b0, 4'hF, 32'h0, 0);
        d_txn(BASE + 32'h1C, 1'b1, 4'h0, 32'h5555AAAA, 0);
        d_txn(BASE + 32'h1C, 1'b0, 4'hF, 32'h0, 0);

        // Same-edge write and fetch of one word
        d_txn(BASE + 32'h20, 1'b1, 4'hF, 32'h00000033, 0);
        fork
            i_txn(BASE + 32'h20);
            d_txn(BASE + 32'h20, 1'b1, 4'hF, 32'h12345678, 0);
        join
        i_txn(BASE + 32'h20);

        i_txn(BASE + 32'hFFC);
        d_txn(BASE + 32'hFFC, 1'b0, 4'hF, 32'h0, 0);
        i_txn(BASE + 32'hFFF);

        // Reset while both ports wait
        daddr = BASE + 32'h14; ddat_w = 32'h0BAD0BAD; dsel = 4'hF; dwe = 1'b1; dcyc = 1'b1; dstb = 1'b1;
        iaddr = BASE + 32'h14; icyc = 1'b1; istb = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_iack", {31'b0, iack}, 32'h0);
        check("midrst_ierr", {31'b0, ierr}, 32'h0);
        check("midrst_idat", idat, 32'h0);
        check("midrst_dack", {31'b0, dack}, 32'h0);
        check("midrst_derr", {31'b0, derr}, 32'h0);
        check("midrst_ddat", ddat_r, 32'h0);
        rst = 1'b0;
        dcyc = 1'b0; dstb = 1'b0; dwe = 1'b0; icyc = 1'b0; istb = 1'b0;
        repeat (W + 3) @(negedge clk);
        d_txn(BASE + 32'h14, 1'b0, 4'hF, 32'h0, 0);

        fork
            for (int t = 0; t < 40; t++) begin
                if ($urandom % 3 == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
                i_txn(pick_addr());
            end
            for (int t = 0; t < 40; t++) begin
                if ($urandom % 3 == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
                d_txn(pick_addr(), 1'($urandom % 2), 4'($urandom), $urandom,
                      ($urandom % 6 == 0) ? int'($urandom_range(1, W)) : 0);
            end
        join

        repeat (W + 4) @(negedge clk);
        check("iq_drained", 32'(iq.size()), 32'h0);
        check("dq_drained", 32'(dq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
